bmu_soft_pipe: RTL

Parametrised, pipelined branch-metric unit for the Viterbi decoder. It generalises the fixed 2-bit hard-decision BMC in three ways:
- any number of code outputs per symbol;
- soft-decision quantisation;
- per-bit erasure (puncturing) support.

Every cycle it accepts one received symbol through a valid/ready handshake and emits the metrics for all 2^N_OUT codewords two cycles later, tagged with a symbol index, to the ACS array.

---
 rtl/bmu_pkg.sv | 37 +++
 rtl/bmu_pipe_stage.sv | 33 +++
 rtl/bmu_soft_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bmu_pkg.sv
// Shared types and helpers for the pipelined soft/hard branch-metric unit.
package bmu_pkg;

  localparam int unsigned MAX_SOFT_W = 8;
  localparam int unsigned MAX_N_OUT  = 4;
  localparam int unsigned NUM_CW_MAX = 1 << MAX_N_OUT;

  // Widest supported soft sample; narrower samples are zero-extended into it.
  typedef logic [MAX_SOFT_W-1:0] soft_t;

  function automatic int unsigned metric_w(input int unsigned soft_w, input int unsigned n_out);
    int unsigned growth;
    growth = $clog2(n_out);
    if (growth < 1) growth = 1;
    return soft_w + growth;
  endfunction

  function automatic int unsigned num_cw(input int unsigned n_out);
    return 1 << n_out;
  endfunction

  // Distance between a received sample and the expected code bit.
  function automatic soft_t bit_dist(input soft_t       sample,
                                     input logic        expected,
                                     input logic        erase,
                                     input logic        soft_mode,
                                     input int unsigned soft_w);
    soft_t mask;
    soft_t msb;
    mask = soft_t'((32'd1 << soft_w) - 32'd1);
    msb  = sample >> (soft_w - 1);
    if (erase) return '0;
    if (soft_mode) return expected ? (mask - sample) : sample;
    return expected ? {{(MAX_SOFT_W-1){1'b0}}, ~msb[0]} : {{(MAX_SOFT_W-1){1'b0}}, msb[0]};
  endfunction

endpackage

// File: rtl/bmu_pipe_stage.sv
// One elastic pipeline slot: payload register plus valid bit with load-when-free logic.
module bmu_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  // Load when empty or when the current contents leave this cycle.
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/bmu_soft_pipe.sv
// Two-stage branch-metric unit: per-bit distances, then all 2^N_OUT codeword sums.
module bmu_soft_pipe
  import bmu_pkg::*;
#(
  parameter  int unsigned N_OUT     = 2,
  parameter  int unsigned SOFT_W    = 3,
  parameter  int unsigned SOFT_MODE = 1,
  parameter  int unsigned IDX_W     = 12,
  localparam int unsigned METRIC_W  = metric_w(SOFT_W, N_OUT),
  localparam int unsigned NUM_CW    = num_cw(N_OUT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [N_OUT*SOFT_W-1:0]      in_rx,
  input  logic [N_OUT-1:0]             in_erase,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CW*METRIC_W-1:0]   out_bm,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_sof
);

  localparam int unsigned DW  = N_OUT * SOFT_W;
  localparam int unsigned S1W = 1 + IDX_W + 2 * DW;
  localparam int unsigned S2W = 1 + IDX_W + NUM_CW * METRIC_W;

  logic [IDX_W-1:0] cnt_q, cnt_d, idx_in;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    idx_in = in_sof ? '0 : cnt_q;
    cnt_d  = accept ? idx_in + IDX_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  logic [DW-1:0] d0_in, d1_in;
  soft_t         smp, dist0, dist1;

  always_comb begin
    d0_in = '0;
    d1_in = '0;
    smp   = '0;
    dist0 = '0;
    dist1 = '0;
    for (int i = 0; i < N_OUT; i++) begin
      smp               = '0;
      smp[SOFT_W-1:0]   = in_rx[i*SOFT_W +: SOFT_W];
      dist0             = bit_dist(smp, 1'b0, in_erase[i], SOFT_MODE != 0, SOFT_W);
      dist1             = bit_dist(smp, 1'b1, in_erase[i], SOFT_MODE != 0, SOFT_W);
      d0_in[i*SOFT_W +: SOFT_W] = dist0[SOFT_W-1:0];
      d1_in[i*SOFT_W +: SOFT_W] = dist1[SOFT_W-1:0];
    end
  end

  logic             s1_valid, s1_ready, s2_ready;
  logic [S1W-1:0]   s1_data;
  logic             s1_sof;
  logic [IDX_W-1:0] s1_idx;
  logic [DW-1:0]    s1_d0, s1_d1;

  bmu_pipe_stage #(
    .Width(S1W)
  ) u_stage1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(in_valid),
    .ready_o(in_ready),
    .data_i ({in_sof, idx_in, d1_in, d0_in}),
    .valid_o(s1_valid),
    .ready_i(s2_ready),
    .data_o (s1_data)
  );

  assign s1_ready = s2_ready;
  assign {s1_sof, s1_idx, s1_d1, s1_d0} = s1_data;

  logic [NUM_CW*METRIC_W-1:0] bm_sum;
  logic [METRIC_W-1:0]        acc;
  logic [SOFT_W-1:0]          term;

  // Codeword bit i selects the distance to '1' or '0' for received bit i.
  always_comb begin
    bm_sum = '0;
    acc    = '0;
    term   = '0;
    for (int c = 0; c < NUM_CW; c++) begin
      acc = '0;
      for (int i = 0; i < N_OUT; i++) begin
        term = (((c >> i) & 1) != 0) ? s1_d1[i*SOFT_W +: SOFT_W] : s1_d0[i*SOFT_W +: SOFT_W];
        acc  = acc + {{(METRIC_W-SOFT_W){1'b0}}, term};
      end
      bm_sum[c*METRIC_W +: METRIC_W] = acc;
    end
  end

  logic [S2W-1:0] s2_data;

  bmu_pipe_stage #(
    .Width(S2W)
  ) u_stage2 (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(s1_valid),
    .ready_o(s2_ready),
    .data_i ({s1_sof, s1_idx, bm_sum}),
    .valid_o(out_valid),
    .ready_i(out_ready),
    .data_o (s2_data)
  );

  assign {out_sof, out_idx, out_bm} = s2_data;

endmodule
